// File: rtl/brainhack_core.sv
// brainhack_core: a two-phase Brainfuck CPU core.
//
// Each instruction takes two clocks. In FETCH the opcode is latched from the
// program ROM. In EXEC it is decoded and executed. The core drives three
// external memories: the program ROM, the data tape RAM and the loop stack RAM.
// All three read asynchronously, and both RAMs write on the rising clock edge.
//
// Ports
//   i_clock        clock; all state changes on the rising edge
//   i_reset_n      asynchronous, active-low reset
//   i_tape_data    tape[o_tape_addr]            (async read)
//   i_prgmem_data  rom[o_prgmem_addr]           (async read)
//   i_stack_data   stack[o_stack_addr]          (async read)
//   o_tape_in      tape write enable
//   o_tape_addr    data pointer (PTR)
//   o_tape_data    tape write data (cell +/- 1)
//   o_prgmem_addr  program counter (PC)
//   o_stack_in     stack write enable
//   o_stack_addr   stack address (SP, or SP-1 while executing ']')
//   o_stack_data   stack write data (PC of the '[')
//   o_halt         high once HALT has executed
module brainhack_core #(
  parameter int TAPE_ADDR_W  = 8,
  parameter int TAPE_DATA_W  = 8,
  parameter int PRG_ADDR_W   = 8,
  parameter int INSTR_W      = 3,
  parameter int STACK_ADDR_W = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic [TAPE_DATA_W-1:0]  i_tape_data,
  input  logic [INSTR_W-1:0]      i_prgmem_data,
  input  logic [PRG_ADDR_W-1:0]   i_stack_data,
  output logic                    o_tape_in,
  output logic [TAPE_ADDR_W-1:0]  o_tape_addr,
  output logic [TAPE_DATA_W-1:0]  o_tape_data,
  output logic [PRG_ADDR_W-1:0]   o_prgmem_addr,
  output logic                    o_stack_in,
  output logic [STACK_ADDR_W-1:0] o_stack_addr,
  output logic [PRG_ADDR_W-1:0]   o_stack_data,
  output logic                    o_halt
);

  localparam logic [INSTR_W-1:0] OP_RIGHT = 3'd0;
  localparam logic [INSTR_W-1:0] OP_LEFT  = 3'd1;
  localparam logic [INSTR_W-1:0] OP_INC   = 3'd2;
  localparam logic [INSTR_W-1:0] OP_DEC   = 3'd3;
  localparam logic [INSTR_W-1:0] OP_HALT  = 3'd4;
  localparam logic [INSTR_W-1:0] OP_NOP   = 3'd5;
  localparam logic [INSTR_W-1:0] OP_OPEN  = 3'd6;
  localparam logic [INSTR_W-1:0] OP_CLOSE = 3'd7;

  typedef enum logic {FETCH, EXEC} stage_t;

  stage_t                  stage_reg;
  logic [PRG_ADDR_W-1:0]   pc_reg;
  logic [TAPE_ADDR_W-1:0]  ptr_reg;
  logic [STACK_ADDR_W-1:0] sp_reg;
  logic [STACK_ADDR_W-1:0] skip_sp_reg;
  logic [INSTR_W-1:0]      ir_reg;
  logic                    skip_reg;
  logic                    halt_reg;

  logic                    exec_active;
  logic                    zero;
  logic [STACK_ADDR_W-1:0] sp_dec;

  // After HALT the core is frozen, so no EXEC phase ever asserts a write again.
  assign exec_active = (stage_reg == EXEC) && !halt_reg;
  assign zero        = (i_tape_data == '0);
  assign sp_dec      = sp_reg - 1'b1;

  // Data ops are suppressed while skipping a loop. Brackets still touch the
  // stack while skipping, because that is how nesting depth is tracked.
  assign o_tape_in    = i_reset_n && exec_active && !skip_reg &&
                        ((ir_reg == OP_INC) || (ir_reg == OP_DEC));
  assign o_tape_data  = (ir_reg == OP_DEC) ? i_tape_data - 1'b1 : i_tape_data + 1'b1;
  assign o_tape_addr  = ptr_reg;
  assign o_prgmem_addr = pc_reg;
  assign o_stack_in   = i_reset_n && exec_active && (ir_reg == OP_OPEN);
  // ']' looks at the top entry, which sits one below SP.
  assign o_stack_addr = (ir_reg == OP_CLOSE) ? sp_dec : sp_reg;
  assign o_stack_data = pc_reg;
  assign o_halt       = halt_reg;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stage_reg   <= FETCH;
      pc_reg      <= '0;
      ptr_reg     <= '0;
      sp_reg      <= '0;
      skip_sp_reg <= '0;
      ir_reg      <= '0;
      skip_reg    <= 1'b0;
      halt_reg    <= 1'b0;
    end else if (!halt_reg) begin
      if (stage_reg == FETCH) begin
        ir_reg    <= i_prgmem_data;
        stage_reg <= EXEC;
      end else begin
        stage_reg <= FETCH;
        pc_reg    <= pc_reg + 1'b1;
        case (ir_reg)
          OP_RIGHT: if (!skip_reg) ptr_reg <= ptr_reg + 1'b1;
          OP_LEFT:  if (!skip_reg) ptr_reg <= ptr_reg - 1'b1;
          OP_HALT: begin
            if (!skip_reg) begin
              halt_reg <= 1'b1;
              pc_reg   <= pc_reg;
            end
          end
          OP_OPEN: begin
            sp_reg <= sp_reg + 1'b1;
            // Remember the depth of the loop that started the skip, so only
            // its own ']' ends it.
            if (zero && !skip_reg) begin
              skip_reg    <= 1'b1;
              skip_sp_reg <= sp_reg;
            end
          end
          OP_CLOSE: begin
            if (!zero && !skip_reg) begin
              // The stack holds the PC of the '['; resume just past it.
              pc_reg <= i_stack_data + 1'b1;
            end else begin
              sp_reg <= sp_dec;
              if (skip_reg && (sp_dec == skip_sp_reg)) skip_reg <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_brainhack_core.sv
module tb_brainhack_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tape_rd;
  logic [2:0] rom_rd;
  logic [7:0] stack_rd;
  logic       tape_we;
  logic [7:0] tape_addr;
  logic [7:0] tape_wdata;
  logic [7:0] pc;
  logic       stack_we;
  logic [3:0] stack_addr;
  logic [7:0] stack_wdata;
  logic       halt;

  always #5 clk = ~clk;

  brainhack_core dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_tape_data   (tape_rd),
    .i_prgmem_data (rom_rd),
    .i_stack_data  (stack_rd),
    .o_tape_in     (tape_we),
    .o_tape_addr   (tape_addr),
    .o_tape_data   (tape_wdata),
    .o_prgmem_addr (pc),
    .o_stack_in    (stack_we),
    .o_stack_addr  (stack_addr),
    .o_stack_data  (stack_wdata),
    .o_halt        (halt)
  );

  // External memories
  logic [7:0] tape_mem [256];
  logic [7:0] stack_mem [16];
  logic [2:0] rom [256];

  assign tape_rd  = tape_mem[tape_addr];
  assign rom_rd   = rom[pc];
  assign stack_rd = stack_mem[stack_addr];

  always @(posedge clk) begin
    if (tape_we) tape_mem[tape_addr] <= tape_wdata;
    if (stack_we) stack_mem[stack_addr] <= stack_wdata;
  end

  int checks = 0;
  int failures = 0;
  int model_tape [256];
  int match_idx [256];

  task automatic check_value(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] enc(input byte c);
    case (c)
      ">": return 3'd0;
      "<": return 3'd1;
      "+": return 3'd2;
      "-": return 3'd3;
      "H": return 3'd4;
      "[": return 3'd6;
      "]": return 3'd7;
      default: return 3'd5;
    endcase
  endfunction

  task automatic load_string(input string s);
    for (int i = 0; i < 256; i++) rom[i] = 3'd4;
    for (int i = 0; i < s.len(); i++) rom[i] = enc(s[i]);
  endtask

  task automatic clear_tape();
    for (int i = 0; i < 256; i++) tape_mem[i] = 8'd0;
    for (int i = 0; i < 16; i++) stack_mem[i] = 8'd0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference interpreter: classic bracket matching. A skipped loop is walked
  // instruction by instruction by the core, so its length is added to the
  // step count; the pushes and pops of a skipped loop cancel out.
  task automatic model_run(output int steps, output int ptr, output int depth,
                           output int hpc, output bit ok);
    int stk[$];
    int p;
    int op;
    for (int i = 0; i < 256; i++) match_idx[i] = i;
    for (int i = 0; i < 256; i++) begin
      if (rom[i] == 3'd6) stk.push_back(i);
      else if (rom[i] == 3'd7 && stk.size() > 0) begin
        p = stk.pop_back();
        match_idx[p] = i;
        match_idx[i] = p;
      end
    end
    steps = 0; ptr = 0; depth = 0; hpc = 0; ok = 0; p = 0;
    while (steps < 3000) begin
      op = int'(rom[p]);
      steps++;
      if (op == 4) begin
        hpc = p; ok = 1;
        return;
      end
      if (op == 6 && model_tape[ptr] == 0) begin
        steps += match_idx[p] - p;
        p = (match_idx[p] + 1) % 256;
        continue;
      end
      if (op == 7 && model_tape[ptr] != 0) begin
        p = (match_idx[p] + 1) % 256;
        continue;
      end
      case (op)
        0: ptr = (ptr + 1) % 256;
        1: ptr = (ptr + 255) % 256;
        2: model_tape[ptr] = (model_tape[ptr] + 1) % 256;
        3: model_tape[ptr] = (model_tape[ptr] + 255) % 256;
        6: depth++;
        7: depth--;
        default: ;
      endcase
      p = (p + 1) % 256;
    end
  endtask

  task automatic run_and_compare(input string tag);
    int steps, mptr, mdepth, mpc, cyc, diff, first_bad;
    bit ok;
    for (int i = 0; i < 256; i++) model_tape[i] = int'(tape_mem[i]);
    model_run(steps, mptr, mdepth, mpc, ok);
    reset_dut();
    cyc = 0;
    while (cyc < 2 * steps + 20 && !halt) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    diff = 0; first_bad = -1;
    for (int i = 0; i < 256; i++) begin
      if (int'(tape_mem[i]) != model_tape[i]) begin
        diff++;
        if (first_bad < 0) first_bad = i;
      end
    end
    check_value({tag, "_halt"}, halt, 1);
    check_value({tag, "_cycles"}, cyc, 2 * steps);
    check_value({tag, "_ptr"}, tape_addr, mptr);
    check_value({tag, "_sp"}, stack_addr, mdepth % 16);
    check_value({tag, "_pc"}, pc, mpc);
    check_value({tag, "_tape_diffs"}, diff, 0);
    $display("run %s: steps=%0d cycles=%0d ptr=%0d first_bad_cell=%0d", tag, steps, cyc,
             tape_addr, first_bad);
  endtask

  task automatic gen_random(output bit ok);
    int len, depth, r, s, mptr, mdepth, mpc;
    for (int attempt = 0; attempt < 50; attempt++) begin
      for (int i = 0; i < 256; i++) rom[i] = 3'd4;
      len = 0; depth = 0;
      for (int i = 0; i < 20; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0 && depth < 4) begin rom[len] = 3'd6; depth++; end
        else if (r == 1 && depth > 0) begin rom[len] = 3'd7; depth--; end
        else begin
          r = $urandom_range(0, 4);
          rom[len] = (r == 4) ? 3'd5 : 3'(r);
        end
        len++;
      end
      while (depth > 0) begin rom[len] = 3'd7; len++; depth--; end
      for (int i = 0; i < 256; i++) tape_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) model_tape[i] = int'(tape_mem[i]);
      model_run(s, mptr, mdepth, mpc, ok);
      if (ok) return;
    end
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    clear_tape();

    // Two clocks per instruction, writes only in EXEC
    load_string("++++H");
    reset_dut();
    check_value("rst_pc", pc, 0);
    check_value("rst_ptr", tape_addr, 0);
    check_value("rst_sp", stack_addr, 0);
    check_value("rst_halt", halt, 0);
    check_value("rst_tape_we", tape_we, 0);
    check_value("rst_stack_we", stack_we, 0);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_value($sformatf("t5_pc_e%0d", n), pc, n / 2);
      check_value($sformatf("t5_we_e%0d", n), tape_we, n % 2);
      check_value($sformatf("t5_swe_e%0d", n), stack_we, 0);
    end

    // Directed programs
    clear_tape(); load_string("+++[>++<-]H"); run_and_compare("t1");
    check_value("t1_tape0", tape_mem[0], 0);
    check_value("t1_tape1", tape_mem[1], 6);
    check_value("t1_ptr_c", tape_addr, 0);
    check_value("t1_sp_c", stack_addr, 0);

    clear_tape(); load_string("[+]+H"); run_and_compare("t2");
    check_value("t2_tape0", tape_mem[0], 1);
    check_value("t2_sp_c", stack_addr, 0);

    clear_tape(); load_string("[[+]+]+H"); run_and_compare("t3");
    check_value("t3_tape0", tape_mem[0], 1);
    check_value("t3_sp_c", stack_addr, 0);

    clear_tape(); load_string("-<H"); run_and_compare("t4");
    check_value("t4_tape0", tape_mem[0], 255);
    check_value("t4_ptr_c", tape_addr, 255);

    // Reset during EXEC of '+'
    clear_tape(); load_string("+++H");
    reset_dut();
    @(posedge clk);
    @(negedge clk);
    check_value("t6_we_before", tape_we, 1);
    rst_n = 1'b0;
    #1;
    check_value("t6_we_in_reset", tape_we, 0);
    check_value("t6_pc_in_reset", pc, 0);
    check_value("t6_ptr_in_reset", tape_addr, 0);
    check_value("t6_sp_in_reset", stack_addr, 0);
    @(posedge clk);
    @(negedge clk);
    check_value("t6_no_write", tape_mem[0], 0);
    run_and_compare("t6");
    check_value("t6_tape0", tape_mem[0], 3);

    // Random well-formed programs on a random tape
    for (int t = 0; t < 15; t++) begin
      gen_random(ok);
      if (ok) run_and_compare($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
